// File: rtl/gpu_alu_issue.sv
// Issue/writeback stage for the GPU ALU: register file, operand issue with WB forwarding,
// result capture and writeback, load-immediate and a combinational debug read port.
module gpu_alu_issue #(
   parameter int DATA_WIDTH = 16,
   parameter int CTRL_WIDTH = 2,
   parameter int NUM_REGS   = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_rd,
   input  logic [ADDR_WIDTH-1:0] cmd_ra,
   input  logic [ADDR_WIDTH-1:0] cmd_rb,
   input  logic [DATA_WIDTH-1:0] cmd_imm,
   output logic [DATA_WIDTH-1:0] alu_inA,
   output logic [DATA_WIDTH-1:0] alu_inB,
   output logic [CTRL_WIDTH-1:0] alu_ctrl,
   input  logic [DATA_WIDTH-1:0] alu_out,
   output logic                  wb_valid,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  err,
   output logic                  busy,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_data
);

   localparam logic [2:0] OP_LOADI = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t                  state_reg;
   state_t                  state_next;
   state_t                  accept_target;
   logic [ADDR_WIDTH-1:0]   rd_reg;
   logic [DATA_WIDTH-1:0]   result_reg;
   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0]     wr_sel;
   logic [DATA_WIDTH-1:0]   op_a;
   logic [DATA_WIDTH-1:0]   op_b;
   logic                    accept;
   logic                    is_alu;
   logic                    is_loadi;
   logic                    is_rsvd;

   assign is_alu   = ~cmd_op[2];
   assign is_loadi = (cmd_op == OP_LOADI);
   assign is_rsvd  = cmd_op[2] & (|cmd_op[1:0]);
   assign accept   = cmd_valid & cmd_ready;

   // Next state, ready, and where an accepted command takes the FSM.
   always_comb begin
      cmd_ready     = 1'b0;
      state_next    = state_reg;
      accept_target = IDLE;
      if (is_alu)
         accept_target = EXEC;
      else if (is_loadi)
         accept_target = WB;
      case (state_reg)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_next = accept_target;
         end
         EXEC: state_next = WB;
         WB: begin
            cmd_ready  = 1'b1;
            state_next = cmd_valid ? accept_target : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // The write of the in-flight result lands on the same edge that issues the
   // next command, so the file is stale for rd during WB; bypass it.
   always_comb begin
      op_a = regs[cmd_ra];
      op_b = regs[cmd_rb];
      if (state_reg == WB && cmd_ra == rd_reg)
         op_a = result_reg;
      if (state_reg == WB && cmd_rb == rd_reg)
         op_b = result_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_reg     <= '0;
         result_reg <= '0;
         alu_inA    <= '0;
         alu_inB    <= '0;
         alu_ctrl   <= '0;
         err        <= 1'b0;
      end else begin
         err <= accept & is_rsvd;
         if (accept && is_alu) begin
            alu_inA  <= op_a;
            alu_inB  <= op_b;
            alu_ctrl <= cmd_op[CTRL_WIDTH-1:0];
            rd_reg   <= cmd_rd;
         end
         if (accept && is_loadi) begin
            result_reg <= cmd_imm;
            rd_reg     <= cmd_rd;
         end else if (state_reg == EXEC) begin
            result_reg <= alu_out;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
         assign wr_sel[gi] = (state_reg == WB) && (rd_reg == ADDR_WIDTH'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++)
            if (wr_sel[i])
               regs[i] <= result_reg;
      end
   end

   assign wb_valid = (state_reg == WB);
   assign wb_addr  = rd_reg;
   assign wb_data  = result_reg;
   assign busy     = (state_reg != IDLE);
   assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_gpu_alu_issue.sv
// Bench for gpu_alu_issue: acts as the combinational ALU and checks against an
// architectural register-file model where every command sees all earlier results.
module tb_gpu_alu_issue;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [2:0]  cmd_rd;
   logic [2:0]  cmd_ra;
   logic [2:0]  cmd_rb;
   logic [15:0] cmd_imm;
   logic [15:0] alu_inA;
   logic [15:0] alu_inB;
   logic [1:0]  alu_ctrl;
   logic [15:0] alu_out;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        err;
   logic        busy;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int          vectors;
   int          miscompares;
   logic [15:0] mregs [8];

   gpu_alu_issue #(.DATA_WIDTH(16), .CTRL_WIDTH(2), .NUM_REGS(8), .ADDR_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
      .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .err(err), .busy(busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Arithmetic of the ALU: wraps at 16 bits, shift amount is the whole B operand.
   function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] c);
      case (c)
         2'd0:    alu_fn = a + b;
         2'd1:    alu_fn = a - b;
         2'd2:    alu_fn = a << b;
         default: alu_fn = a >> b;
      endcase
   endfunction

   assign alu_out = alu_fn(alu_inA, alu_inB, alu_ctrl);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic model_apply(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                              input logic [2:0] rb, input logic [15:0] imm);
      if (op < 3'd4)
         mregs[rd] = alu_fn(mregs[ra], mregs[rb], op[1:0]);
      else if (op == 3'd4)
         mregs[rd] = imm;
   endtask

   // Drives one command from the next falling edge; returns just after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [15:0] imm);
      bit done;
      done = 0;
      @(negedge clk);
      cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (cmd_ready) begin
            @(posedge clk);
            done = 1;
            break;
         end
         @(negedge clk);
      end
      #1 cmd_valid = 1'b0;
      $display("txn op=%0d rd=%0d ra=%0d rb=%0d imm=%h", op, rd, ra, rb, imm);
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout op=%0d got cmd_ready=%b exp=1 within 8 cycles", op, cmd_ready);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
      cmd_imm = '0; dbg_addr = '0;
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b exp=0", err); end
      vectors++; if ({alu_inA, alu_inB, alu_ctrl} !== 34'h0) begin miscompares++; $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_inA, alu_inB, alu_ctrl); end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL rst_reg%0d got=%h exp=0000", i, dbg_data); end
      end
   endtask

   task automatic test_loadi_add;
      send(3'd4, 3'd1, 3'd0, 3'd0, 16'h0005); model_apply(3'd4, 3'd1, 3'd0, 3'd0, 16'h0005);
      send(3'd4, 3'd2, 3'd0, 3'd0, 16'h0003); model_apply(3'd4, 3'd2, 3'd0, 3'd0, 16'h0003);
      send(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000); model_apply(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000);
      @(negedge clk);
      vectors++; if (alu_inA !== 16'h0005) begin miscompares++; $display("FAIL add_inA got=%h exp=0005", alu_inA); end
      vectors++; if (alu_inB !== 16'h0003) begin miscompares++; $display("FAIL add_inB got=%h exp=0003", alu_inB); end
      vectors++; if (alu_ctrl !== 2'd0) begin miscompares++; $display("FAIL add_ctrl got=%0d exp=0", alu_ctrl); end
      vectors++; if (cmd_ready !== 1'b0 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL add_exec got ready=%b wb=%b exp 0/0", cmd_ready, wb_valid); end
      @(negedge clk);
      vectors++; if (wb_valid !== 1'b1 || wb_addr !== 3'd3 || wb_data !== 16'h0008) begin miscompares++; $display("FAIL add_wb got v=%b a=%0d d=%h exp 1/3/0008", wb_valid, wb_addr, wb_data); end
      dbg_addr = 3'd3; #1;
      vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL add_prewrite got=%h exp=0000", dbg_data); end
      @(negedge clk);
      vectors++; if (dbg_data !== 16'h0008) begin miscompares++; $display("FAIL add_r3 got=%h exp=0008", dbg_data); end
   endtask

   task automatic test_sub_wrap;
      send(3'd4, 3'd1, 3'd0, 3'd0, 16'h0000); model_apply(3'd4, 3'd1, 3'd0, 3'd0, 16'h0000);
      send(3'd4, 3'd2, 3'd0, 3'd0, 16'h0001); model_apply(3'd4, 3'd2, 3'd0, 3'd0, 16'h0001);
      send(3'd1, 3'd4, 3'd1, 3'd2, 16'h0000); model_apply(3'd1, 3'd4, 3'd1, 3'd2, 16'h0000);
      // Waits out EXEC, then issues in the SUB's WB cycle with r4 forwarded.
      send(3'd0, 3'd5, 3'd4, 3'd2, 16'h0000); model_apply(3'd0, 3'd5, 3'd4, 3'd2, 16'h0000);
      @(negedge clk);
      vectors++; if (alu_inA !== 16'hFFFF || alu_inB !== 16'h0001) begin miscompares++; $display("FAIL wrap_ops got=%h/%h exp=FFFF/0001", alu_inA, alu_inB); end
      @(negedge clk);
      vectors++; if (wb_valid !== 1'b1 || wb_addr !== 3'd5 || wb_data !== 16'h0000) begin miscompares++; $display("FAIL wrap_wb got v=%b a=%0d d=%h exp 1/5/0000", wb_valid, wb_addr, wb_data); end
      @(negedge clk);
      dbg_addr = 3'd4; #1;
      vectors++; if (dbg_data !== 16'hFFFF) begin miscompares++; $display("FAIL sub_r4 got=%h exp=FFFF", dbg_data); end
      dbg_addr = 3'd5; #1;
      vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL wrap_r5 got=%h exp=0000", dbg_data); end
   endtask

   task automatic test_forward;
      send(3'd4, 3'd2, 3'd0, 3'd0, 16'h0002); model_apply(3'd4, 3'd2, 3'd0, 3'd0, 16'h0002);
      send(3'd4, 3'd1, 3'd0, 3'd0, 16'h0010); model_apply(3'd4, 3'd1, 3'd0, 3'd0, 16'h0010);
      send(3'd2, 3'd6, 3'd1, 3'd2, 16'h0000); model_apply(3'd2, 3'd6, 3'd1, 3'd2, 16'h0000);
      @(negedge clk);
      vectors++; if (alu_inA !== 16'h0010 || alu_inB !== 16'h0002 || alu_ctrl !== 2'd2) begin miscompares++; $display("FAIL fwd_sl_ops got=%h/%h/%0d exp=0010/0002/2", alu_inA, alu_inB, alu_ctrl); end
      @(negedge clk);
      vectors++; if (wb_valid !== 1'b1 || wb_addr !== 3'd6 || wb_data !== 16'h0040) begin miscompares++; $display("FAIL fwd_sl_wb got v=%b a=%0d d=%h exp 1/6/0040", wb_valid, wb_addr, wb_data); end
      // r2 goes 7 -> 2 back to back, so only forwarding supplies the fresh 2 on B.
      send(3'd4, 3'd2, 3'd0, 3'd0, 16'h0007); model_apply(3'd4, 3'd2, 3'd0, 3'd0, 16'h0007);
      send(3'd4, 3'd2, 3'd0, 3'd0, 16'h0002); model_apply(3'd4, 3'd2, 3'd0, 3'd0, 16'h0002);
      send(3'd3, 3'd6, 3'd1, 3'd2, 16'h0000); model_apply(3'd3, 3'd6, 3'd1, 3'd2, 16'h0000);
      @(negedge clk);
      vectors++; if (alu_inA !== 16'h0010 || alu_inB !== 16'h0002 || alu_ctrl !== 2'd3) begin miscompares++; $display("FAIL fwd_sr_ops got=%h/%h/%0d exp=0010/0002/3", alu_inA, alu_inB, alu_ctrl); end
      @(negedge clk);
      vectors++; if (wb_data !== 16'h0004 || wb_addr !== 3'd6) begin miscompares++; $display("FAIL fwd_sr_wb got a=%0d d=%h exp 6/0004", wb_addr, wb_data); end
      send(3'd4, 3'd7, 3'd0, 3'd0, 16'h0003); model_apply(3'd4, 3'd7, 3'd0, 3'd0, 16'h0003);
      send(3'd0, 3'd7, 3'd7, 3'd7, 16'h0000); model_apply(3'd0, 3'd7, 3'd7, 3'd7, 16'h0000);
      @(negedge clk);
      vectors++; if (alu_inA !== 16'h0003 || alu_inB !== 16'h0003) begin miscompares++; $display("FAIL fwd_both_ops got=%h/%h exp=0003/0003", alu_inA, alu_inB); end
      @(negedge clk);
      vectors++; if (wb_data !== 16'h0006 || wb_addr !== 3'd7) begin miscompares++; $display("FAIL fwd_both_wb got a=%0d d=%h exp 7/0006", wb_addr, wb_data); end
   endtask

   task automatic test_stall_err;
      logic [15:0] ea, eb, ex;
      send(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000);
      ex = alu_fn(mregs[1], mregs[2], 2'd0);
      model_apply(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000);
      @(negedge clk);
      cmd_op = 3'd0; cmd_rd = 3'd5; cmd_ra = 3'd6; cmd_rb = 3'd7; cmd_imm = 16'h0000; cmd_valid = 1'b1;
      #1;
      vectors++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL stall_exec got ready=%b busy=%b exp 0/1", cmd_ready, busy); end
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b1 || wb_valid !== 1'b1 || wb_addr !== 3'd3 || wb_data !== ex) begin miscompares++; $display("FAIL stall_wb got r=%b v=%b a=%0d d=%h exp 1/1/3/%h", cmd_ready, wb_valid, wb_addr, wb_data, ex); end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      $display("txn op=0 rd=5 ra=6 rb=7 imm=0000");
      ea = mregs[6]; eb = mregs[7];
      model_apply(3'd0, 3'd5, 3'd6, 3'd7, 16'h0000);
      @(negedge clk);
      vectors++; if (alu_inA !== ea || alu_inB !== eb || wb_valid !== 1'b0) begin miscompares++; $display("FAIL stall_issue got=%h/%h wb=%b exp=%h/%h wb=0", alu_inA, alu_inB, wb_valid, ea, eb); end
      @(negedge clk);
      vectors++; if (wb_valid !== 1'b1 || wb_addr !== 3'd5 || wb_data !== mregs[5]) begin miscompares++; $display("FAIL stall_result got v=%b a=%0d d=%h exp 1/5/%h", wb_valid, wb_addr, wb_data, mregs[5]); end
      send(3'd6, 3'd1, 3'd1, 3'd1, 16'hAAAA);
      @(negedge clk);
      vectors++; if (err !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rsvd_pulse got err=%b wb=%b busy=%b exp 1/0/0", err, wb_valid, busy); end
      vectors++; if (alu_inA !== ea || alu_inB !== eb) begin miscompares++; $display("FAIL rsvd_hold got=%h/%h exp=%h/%h", alu_inA, alu_inB, ea, eb); end
      @(negedge clk);
      vectors++; if (err !== 1'b0 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL rsvd_end got err=%b wb=%b exp 0/0", err, wb_valid); end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         vectors++; if (dbg_data !== mregs[i]) begin miscompares++; $display("FAIL rsvd_reg%0d got=%h exp=%h", i, dbg_data, mregs[i]); end
      end
   endtask

   task automatic test_async_reset;
      send(3'd4, 3'd1, 3'd0, 3'd0, 16'h1234);
      send(3'd0, 3'd2, 3'd1, 3'd1, 16'h0000);
      @(negedge clk);
      dbg_addr = 3'd1; #1;
      vectors++; if (busy !== 1'b1 || dbg_data !== 16'h1234) begin miscompares++; $display("FAIL arst_pre got busy=%b r1=%h exp 1/1234", busy, dbg_data); end
      #1 rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0 || alu_inA !== 16'h0000 || alu_inB !== 16'h0000 || dbg_data !== 16'h0000) begin
         miscompares++; $display("FAIL arst_now got busy=%b wb=%b err=%b inA=%h inB=%h r1=%h exp all 0", busy, wb_valid, err, alu_inA, alu_inB, dbg_data);
      end
      repeat (2) @(negedge clk);
      vectors++; if (wb_valid !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL arst_hold got wb=%b ready=%b exp 0/1", wb_valid, cmd_ready); end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL arst_reg%0d got=%h exp=0000", i, dbg_data); end
      end
      send(3'd4, 3'd0, 3'd0, 3'd0, 16'hBEEF); model_apply(3'd4, 3'd0, 3'd0, 3'd0, 16'hBEEF);
      @(negedge clk);
      vectors++; if (wb_valid !== 1'b1 || wb_addr !== 3'd0 || wb_data !== 16'hBEEF) begin miscompares++; $display("FAIL arst_new got v=%b a=%0d d=%h exp 1/0/BEEF", wb_valid, wb_addr, wb_data); end
      @(negedge clk);
      dbg_addr = 3'd0; #1;
      vectors++; if (dbg_data !== 16'hBEEF) begin miscompares++; $display("FAIL arst_r0 got=%h exp=BEEF", dbg_data); end
   endtask

   task automatic test_back_to_back;
      logic [2:0]  prd;
      logic [15:0] pimm;
      prd = '0; pimm = '0;
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            vectors++; if (wb_valid !== 1'b1 || wb_addr !== prd || wb_data !== pimm || cmd_ready !== 1'b1) begin
               miscompares++; $display("FAIL b2b_%0d got v=%b a=%0d d=%h r=%b exp 1/%0d/%h/1", i, wb_valid, wb_addr, wb_data, cmd_ready, prd, pimm);
            end
         end
         if (i < 6) begin
            prd = 3'($urandom_range(0, 7)); pimm = 16'($urandom);
            cmd_op = 3'd4; cmd_rd = prd; cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_imm = pimm; cmd_valid = 1'b1;
            model_apply(3'd4, prd, 3'd0, 3'd0, pimm);
            $display("txn op=4 rd=%0d ra=0 rb=0 imm=%h", prd, pimm);
         end else begin
            cmd_valid = 1'b0;
         end
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         vectors++; if (dbg_data !== mregs[i]) begin miscompares++; $display("FAIL b2b_reg%0d got=%h exp=%h", i, dbg_data, mregs[i]); end
      end
   endtask

   task automatic test_random;
      logic [2:0]  op, rd, ra, rb;
      logic [15:0] imm, ea, eb, ex, old;
      for (int n = 0; n < 80; n++) begin
         op = ($urandom_range(0, 11) < 10) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         rd = 3'($urandom_range(0, 7)); ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7));
         imm = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
         ea = mregs[ra]; eb = mregs[rb]; old = mregs[rd];
         ex = (op == 3'd4) ? imm : alu_fn(ea, eb, op[1:0]);
         send(op, rd, ra, rb, imm);
         @(negedge clk);
         if (op < 3'd4) begin
            vectors++; if (alu_inA !== ea || alu_inB !== eb || alu_ctrl !== op[1:0]) begin miscompares++; $display("FAIL rnd%0d_ops got=%h/%h/%0d exp=%h/%h/%0d", n, alu_inA, alu_inB, alu_ctrl, ea, eb, op[1:0]); end
            @(negedge clk);
         end
         if (op <= 3'd4) begin
            vectors++; if (wb_valid !== 1'b1 || wb_addr !== rd || wb_data !== ex) begin miscompares++; $display("FAIL rnd%0d_wb got v=%b a=%0d d=%h exp 1/%0d/%h", n, wb_valid, wb_addr, wb_data, rd, ex); end
            dbg_addr = rd; #1;
            vectors++; if (dbg_data !== old) begin miscompares++; $display("FAIL rnd%0d_prewrite got=%h exp=%h", n, dbg_data, old); end
         end else begin
            vectors++; if (err !== 1'b1 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_rsvd got err=%b wb=%b exp 1/0", n, err, wb_valid); end
         end
         model_apply(op, rd, ra, rb, imm);
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         vectors++; if (dbg_data !== mregs[i]) begin miscompares++; $display("FAIL rnd_reg%0d got=%h exp=%h", i, dbg_data, mregs[i]); end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_loadi_add();
      test_sub_wrap();
      test_forward();
      test_stall_err();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
